cargador_operandos: RTL and testbench

CARGADOR_OPERANDOS -- requirements
Module: cargador_operandos

---
 rtl/cargador_operandos.sv | 80 ++++++++
 tb/tb_cargador_operandos.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cargador_operandos.sv
// ============================================================================
// cargador_operandos
// Loads two operands from a shared bus and captures the sum from an external adder.
// Rev 1.0
// ============================================================================
`default_nettype none

module cargador_operandos #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dato_in,
    input  logic             dato_valid,
    output logic             dato_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] res_in,
    output logic [WIDTH-1:0] res_out,
    output logic             acarreo,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [7:0]       cuenta_ops
);

    localparam logic [1:0] ESPERA_A = 2'd0;
    localparam logic [1:0] ESPERA_B = 2'd1;
    localparam logic [1:0] SUMA     = 2'd2;
    localparam logic [1:0] ENTREGA  = 2'd3;

    logic [1:0] state;
    logic       transfer;

    // Handshake outputs are pure state decodes, so no path exists from dato_valid.
    assign dato_ready = (state == ESPERA_A) || (state == ESPERA_B);
    assign res_valid  = (state == ENTREGA);
    assign transfer   = dato_valid && dato_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ESPERA_A;
            op_a       <= '0;
            op_b       <= '0;
            res_out    <= '0;
            acarreo    <= 1'b0;
            cuenta_ops <= 8'd0;
        end else begin
            case (state)
                ESPERA_A: begin
                    if (transfer) begin
                        op_a  <= dato_in;
                        state <= ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (transfer) begin
                        op_b  <= dato_in;
                        state <= SUMA;
                    end
                end
                SUMA: begin
                    // A wrapped sum is smaller than either addend exactly when it overflowed.
                    res_out <= res_in;
                    acarreo <= (res_in < op_a);
                    state   <= ENTREGA;
                end
                ENTREGA: begin
                    if (res_ack) begin
                        cuenta_ops <= cuenta_ops + 8'd1;
                        state      <= ESPERA_A;
                    end
                end
                default: state <= ESPERA_A;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cargador_operandos.sv
// ============================================================================
// tb_cargador_operandos
// Directed self-checking bench; models the external adder on res_in.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cargador_operandos;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] dato_in;
    logic             dato_valid;
    logic             dato_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_in;
    logic [WIDTH-1:0] res_out;
    logic             acarreo;
    logic             res_valid;
    logic             res_ack;
    logic [7:0]       cuenta_ops;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_cnt;

    cargador_operandos #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dato_in    (dato_in),
        .dato_valid (dato_valid),
        .dato_ready (dato_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_in     (res_in),
        .res_out    (res_out),
        .acarreo    (acarreo),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .cuenta_ops (cuenta_ops)
    );

    // External adder
    assign res_in = op_a + op_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                          input bit early_ack, input bit junk);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        check("ready_idle", dato_ready, 1);
        dato_valid = 1'b1;
        dato_in    = a;
        @(posedge clk); #1;
        check("op_a_load", op_a, a);
        check("ready_b", dato_ready, 1);
        dato_in = b;
        if (early_ack) res_ack = 1'b1;
        @(posedge clk); #1;
        check("op_b_load", op_b, b);
        check("ready_suma", dato_ready, 0);
        check("valid_suma", res_valid, 0);
        if (junk) dato_in = 4'd7;
        else      dato_valid = 1'b0;
        @(posedge clk); #1;
        check("res_out", res_out, sum[3:0]);
        check("acarreo", acarreo, sum[4]);
        check("valid_entrega", res_valid, 1);
        check("ready_entrega", dato_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("valid_hold", res_valid, 1);
            check("res_hold", res_out, sum[3:0]);
            check("ready_hold", dato_ready, 0);
            check("cnt_hold", cuenta_ops, exp_cnt);
        end
        res_ack = 1'b1;
        @(posedge clk); #1;
        res_ack    = 1'b0;
        dato_valid = 1'b0;
        exp_cnt    = exp_cnt + 8'd1;
        check("cnt_after_ack", cuenta_ops, exp_cnt);
        check("valid_after_ack", res_valid, 0);
        check("ready_after_ack", dato_ready, 1);
        check("op_a_kept", op_a, a);
        check("op_b_kept", op_b, b);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_res_out", res_out, 0);
        check("rst_acarreo", acarreo, 0);
        check("rst_valid", res_valid, 0);
        check("rst_cnt", cuenta_ops, 0);
        check("rst_ready", dato_ready, 1);
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        time t0;
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 8'd0;
        rst_n        = 1'b0;
        dato_in      = '0;
        dato_valid   = 1'b0;
        res_ack      = 1'b0;

        #2;
        check("por_ready", dato_ready, 1);
        check("por_valid", res_valid, 0);
        check("por_cnt", cuenta_ops, 0);
        check("por_res_out", res_out, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(4'd0, 4'd4, 0, 1'b1, 1'b0);
        run_op(4'd1, 4'd10, 0, 1'b0, 1'b0);
        run_op(4'd10, 4'd9, 0, 1'b0, 1'b0);
        run_op(4'd14, 4'd1, 5, 1'b0, 1'b0);
        run_op(4'd3, 4'd5, 2, 1'b0, 1'b1);
        run_op(4'd6, 4'd8, 0, 1'b0, 1'b0);

        // Abort a partly loaded operation
        dato_valid = 1'b1;
        dato_in    = 4'd2;
        @(posedge clk); #1;
        dato_valid = 1'b0;
        check("mid_op_a", op_a, 2);
        pulse_reset();
        run_op(4'd2, 4'd4, 0, 1'b0, 1'b0);
        check("post_rst_cnt", cuenta_ops, 1);

        pulse_reset();
        t0 = $time;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] bv;
            bv = i * 7;
            run_op(i[3:0], bv[3:0], 0, 1'b1, 1'b0);
        end
        check("burst_time", 32'($time - t0), 32'd10240);
        check("cnt_wrap", cuenta_ops, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
